// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the machine word, the NOP encoding and the
// halfword-alignment helper used wherever a fetch target enters the pipeline.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam lc3b_word LC3B_NOP = 16'h0000;

  // Instruction addresses are halfword aligned; force bit 0 low.
  function automatic lc3b_word align_word(input lc3b_word addr);
    return addr & ~16'h0001;
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// LC-3b instruction fetch stage. Issues one instruction-memory read at a time,
// hands the returned word to the IF/ID latch in the same cycle when possible,
// parks it in a hold buffer while the latch is stalled, and squashes a read
// that is already outstanding when a redirect arrives before it completes.
module ifetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output logic     imem_read,
  output lc3b_word imem_address,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  input  logic     stall,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output logic     ifid_load,
  output lc3b_word pc_out,
  output lc3b_word instruction_out
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  fetch_state_t state;
  lc3b_word     pc;
  lc3b_word     buffer;
  lc3b_word     pending;

  lc3b_word     pc_plus2;
  lc3b_word     target;

  // 16-bit add wraps naturally: 16'hFFFE + 2 = 16'h0000.
  assign pc_plus2 = pc + 16'd2;
  assign target   = align_word(redirect_pc);

  // Outputs to memory and to the IF/ID latch, decoded from state and inputs so
  // a returning word can be delivered in the cycle it arrives.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    imem_read       = 1'b0;
    imem_address    = pc;
    ifid_load       = 1'b0;
    pc_out          = LC3B_NOP;
    instruction_out = LC3B_NOP;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          imem_read = 1'b1;
          if (imem_resp && !redirect && !stall) begin
            ifid_load       = 1'b1;
            pc_out          = pc_plus2;
            instruction_out = imem_rdata;
          end else begin
            ifid_load = !stall;
          end
        end
        HOLD: begin
          if (!redirect && !stall) begin
            ifid_load       = 1'b1;
            pc_out          = pc_plus2;
            instruction_out = buffer;
          end else begin
            ifid_load = !stall;
          end
        end
        SQUASH: begin
          // The stale read cannot be withdrawn, so keep presenting its address.
          imem_read = 1'b1;
          ifid_load = !stall;
        end
        default: ;
      endcase
    end
  end

  // Fetch state machine with pc, hold buffer and pending redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      // NOTE: buffer and pending are plain registers, not a memory array, so
      // clearing them at reset is cheap and keeps stale data from ever leaking.
      buffer  <= LC3B_NOP;
      pending <= LC3B_NOP;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its sources, independent of statement order.
      unique case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_resp) begin
              pc <= target;
            end else begin
              pending <= target;
              state   <= SQUASH;
            end
          end else if (imem_resp) begin
            if (stall) begin
              buffer <= imem_rdata;
              state  <= HOLD;
            end else begin
              pc <= pc_plus2;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus2;
            state <= FETCH;
          end
        end
        SQUASH: begin
          if (imem_resp) begin
            // A redirect landing with the response is newer than pending.
            pc    <= redirect ? target : pending;
            state <= FETCH;
          end else if (redirect) begin
            pending <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit. Stimulus pushes expected fetch addresses and
// expected IF/ID deliveries into queues; a monitor pops and compares whenever
// the DUT completes a read or loads a real instruction. A second instance with
// RESET_PC=16'hFFFE covers the pc+2 wraparound.
module tb_ifetch_unit;
  import lc3b_types::*;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } deliv_t;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  logic     imem_read;
  lc3b_word imem_address;
  lc3b_word imem_rdata = 16'h0000;
  logic     imem_resp = 1'b0;
  logic     stall = 1'b0;
  logic     redirect = 1'b0;
  lc3b_word redirect_pc = 16'h0000;
  logic     ifid_load;
  lc3b_word pc_out;
  lc3b_word instruction_out;

  logic     w_imem_read;
  lc3b_word w_imem_address;
  lc3b_word w_imem_rdata = 16'h0000;
  logic     w_imem_resp = 1'b0;
  logic     w_stall = 1'b0;
  logic     w_redirect = 1'b0;
  lc3b_word w_redirect_pc = 16'h0000;
  logic     w_ifid_load;
  lc3b_word w_pc_out;
  lc3b_word w_instruction_out;

  int checks = 0;
  int errors = 0;

  lc3b_word exp_addr[$];
  deliv_t   exp_deliv[$];

  ifetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_load(ifid_load), .pc_out(pc_out), .instruction_out(instruction_out)
  );

  ifetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset(reset),
    .imem_read(w_imem_read), .imem_address(w_imem_address),
    .imem_rdata(w_imem_rdata), .imem_resp(w_imem_resp),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .ifid_load(w_ifid_load), .pc_out(w_pc_out), .instruction_out(w_instruction_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: drive inputs just after the rising edge, return at the falling
  // edge with outputs settled for sampling.
  task automatic cyc(input logic rst, input logic resp, input lc3b_word rdata,
                     input logic stl, input logic rdr, input lc3b_word rpc);
    @(posedge clk);
    #1;
    reset       = rst;
    imem_resp   = resp;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic push_addr(input lc3b_word a);
    exp_addr.push_back(a);
  endtask

  task automatic push_deliv(input lc3b_word p, input lc3b_word i);
    deliv_t d;
    d.pc    = p;
    d.instr = i;
    exp_deliv.push_back(d);
  endtask

  // Monitor: completed reads and real IF/ID loads are matched against queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_read && imem_resp) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_read_completion", imem_address, 16'hxxxx);
        end else begin
          check("read_address", imem_address, exp_addr.pop_front());
        end
      end
      if (ifid_load && instruction_out != LC3B_NOP) begin
        if (exp_deliv.size() == 0) begin
          check("unexpected_delivery", instruction_out, 16'hxxxx);
        end else begin
          deliv_t d;
          d = exp_deliv.pop_front();
          check("deliv_pc_out", pc_out, d.pc);
          check("deliv_instr", instruction_out, d.instr);
        end
      end else if (ifid_load) begin
        check("bubble_pc_out", pc_out, 16'h0000);
      end
    end
  end

  initial begin
    // Reset behaviour
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    check("rst_imem_read", {15'd0, imem_read}, 16'd0);
    check("rst_ifid_load", {15'd0, ifid_load}, 16'd0);
    check("rst_instr", instruction_out, 16'h0000);
    check("rst_pc_out", pc_out, 16'h0000);

    // Response every second cycle, no stall
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("first_read", {15'd0, imem_read}, 16'd1);
    check("first_addr", imem_address, 16'h0000);
    check("bubble_load", {15'd0, ifid_load}, 16'd1);
    check("bubble_instr", instruction_out, LC3B_NOP);
    push_addr(16'h0000); push_deliv(16'h0002, 16'h1234);
    cyc(0, 1, 16'h1234, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("second_addr", imem_address, 16'h0002);
    push_addr(16'h0002); push_deliv(16'h0004, 16'h5678);
    cyc(0, 1, 16'h5678, 0, 0, 16'h0);

    // Stall at response for three cycles
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    push_addr(16'h0004);
    cyc(0, 1, 16'hABCD, 1, 0, 16'h0);
    check("stall_resp_load", {15'd0, ifid_load}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 16'h0, 1, 0, 16'h0);
      check("hold_read", {15'd0, imem_read}, 16'd0);
      check("hold_load", {15'd0, ifid_load}, 16'd0);
    end
    push_deliv(16'h0006, 16'hABCD);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("release_load", {15'd0, ifid_load}, 16'd1);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("after_hold_addr", imem_address, 16'h0006);

    // Redirect while request outstanding: old address held, data dropped
    cyc(0, 0, 16'h0, 0, 1, 16'h3001);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("squash_read", {15'd0, imem_read}, 16'd1);
    check("squash_addr", imem_address, 16'h0006);
    push_addr(16'h0006);
    cyc(0, 1, 16'hDEAD, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("redirect_addr", imem_address, 16'h3000);

    // Second redirect while squashing overwrites the pending target
    cyc(0, 0, 16'h0, 0, 1, 16'h5000);
    cyc(0, 0, 16'h0, 0, 1, 16'h6000);
    check("squash2_addr", imem_address, 16'h3000);
    push_addr(16'h3000);
    cyc(0, 1, 16'hDEAD, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("overwrite_addr", imem_address, 16'h6000);

    // Redirect coincident with response
    push_addr(16'h6000);
    cyc(0, 1, 16'hBEEF, 0, 1, 16'h4000);
    check("coinc_instr", instruction_out, LC3B_NOP);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("coinc_addr", imem_address, 16'h4000);

    // Redirect beats stall in HOLD; bit 0 of target ignored
    push_addr(16'h4000);
    cyc(0, 1, 16'h1357, 1, 0, 16'h0);
    cyc(0, 0, 16'h0, 1, 1, 16'h2223);
    check("hold_redirect_load", {15'd0, ifid_load}, 16'd0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("hold_redirect_addr", imem_address, 16'h2222);

    // Reset while in HOLD: buffered word never delivered
    push_addr(16'h2222);
    cyc(0, 1, 16'h2468, 1, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    check("rst_hold_read", {15'd0, imem_read}, 16'd0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("rst_hold_addr", imem_address, 16'h0000);
    push_addr(16'h0000); push_deliv(16'h0002, 16'h1111);
    cyc(0, 1, 16'h1111, 0, 0, 16'h0);

    // Reset while in SQUASH: pending target discarded
    cyc(0, 0, 16'h0, 0, 1, 16'h7000);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("rst_squash_addr", imem_address, 16'h0000);
    push_addr(16'h0000); push_deliv(16'h0002, 16'h9999);
    cyc(0, 1, 16'h9999, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("post_rst_addr", imem_address, 16'h0002);

    // Wraparound instance: RESET_PC=16'hFFFE, immediate response
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    w_imem_resp  = 1'b1;
    w_imem_rdata = 16'h0F0F;
    #1;
    check("wrap_addr", w_imem_address, 16'hFFFE);
    check("wrap_load", {15'd0, w_ifid_load}, 16'd1);
    check("wrap_pc_out", w_pc_out, 16'h0000);
    check("wrap_instr", w_instruction_out, 16'h0F0F);
    @(posedge clk);
    #1;
    w_imem_resp = 1'b0;
    @(negedge clk);
    check("wrap_next_addr", w_imem_address, 16'h0000);

    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    check("addr_queue_empty", 16'(exp_addr.size()), 16'd0);
    check("deliv_queue_empty", 16'(exp_deliv.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_read  out  1  instruction-memory read request, held until imem_resp.
REQ-005 SHALL have port imem_address  out  16 (lc3b_word)  fetch address, bit 0 always 0.
REQ-006 SHALL have port imem_rdata  in  16 (lc3b_word)  read data, valid only when imem_resp=1.
REQ-007 SHALL have port imem_resp  in  1  single-cycle read completion.
REQ-008 SHALL have port stall  in  1  IF/ID latch cannot accept this cycle.
REQ-009 SHALL have port redirect  in  1  branch/jump taken; fetch from redirect_pc.
REQ-010 SHALL have port redirect_pc  in  16 (lc3b_word)  redirect target, bit 0 ignored.
REQ-011 SHALL have port ifid_load  out  1  load strobe to the IF/ID latch.
REQ-012 SHALL have port pc_out  out  16 (lc3b_word)  fetched address + 2 (LC-3b incremented-PC convention).
REQ-013 SHALL have port instruction_out  out  16 (lc3b_word)  instruction or NOP 16'h0000.

Function
REQ-014 SHALL implement states FETCH, HOLD, SQUASH, plus a 16-bit pc, 16-bit hold buffer and 16-bit pending target register.
REQ-015 FETCH: imem_read=1, imem_address=pc.
REQ-016 FETCH, imem_resp=1, redirect=0, stall=0: ifid_load=1, instruction_out=imem_rdata, pc_out=pc+2 same cycle (zero latency); pc<=pc+2; stay FETCH.
REQ-017 FETCH, imem_resp=1, redirect=0, stall=1: ifid_load=0; buffer<=imem_rdata; go HOLD.
REQ-018 FETCH, imem_resp=1, redirect=1: instruction discarded; pc<={redirect_pc[15:1],1'b0}; stay FETCH.
REQ-019 FETCH, imem_resp=0, redirect=1: pending<={redirect_pc[15:1],1'b0}; go SQUASH (request cannot be withdrawn).
REQ-020 HOLD: imem_read=0; on stall=0 and redirect=0: ifid_load=1, instruction_out=buffer, pc_out=pc+2; pc<=pc+2; go FETCH.
REQ-021 HOLD, redirect=1: buffer discarded; pc<=redirect target; go FETCH.
REQ-022 SQUASH: imem_read=1, imem_address=pc (old address); on imem_resp: data discarded, pc<=pending, go FETCH; new redirect in SQUASH overwrites pending (redirect coincident with imem_resp uses redirect_pc, not pending).
REQ-023 Any cycle with no instruction delivered: instruction_out=16'h0000, pc_out=16'h0000, ifid_load=!stall (bubble insertion).
REQ-024 redirect SHALL take priority over stall and over imem_resp delivery in every state.
REQ-025 pc+2 SHALL wrap modulo 2^16: 16'hFFFE -> 16'h0000; pc_out for address 16'hFFFE SHALL be 16'h0000.
REQ-026 imem_address SHALL be stable while imem_read=1 and imem_resp=0.

Reset
REQ-027 reset=1 at a clock edge SHALL set state=FETCH, pc=RESET_PC, buffer=16'h0000, pending=16'h0000, regardless of outstanding request or state.
REQ-028 During reset cycles imem_read=0, ifid_load=0, instruction_out=16'h0000, pc_out=16'h0000; first cycle after reset imem_read=1, imem_address=RESET_PC.

Structure
REQ-029 lc3b_word and constant LC3B_NOP (16'h0000) SHALL come from package lc3b_types; fetch state enum SHALL be local to ifetch_unit.
REQ-030 No sub-module required; pc, buffer, pending SHALL be plain registers in ifetch_unit (120-250 lines RTL).

Verification
REQ-031 Reset, imem_resp every 2nd cycle, rdata 16'h1234/16'h5678, stall=0 -> addresses 0000,0002; two ifid_load pulses with pc_out 0002,0004; NOP bubbles between.
REQ-032 stall=1 for 3 cycles at resp with rdata 16'hABCD -> imem_read drops, ifid_load=0; on stall release ifid_load=1, instruction_out=ABCD, next address +2.
REQ-033 redirect to 16'h3001 while request outstanding -> old address held until resp, resp data discarded, next imem_address=3000.
REQ-034 redirect to 16'h4000 coincident with imem_resp -> no ifid_load of that data; next imem_address=4000.
REQ-035 RESET_PC=16'hFFFE, resp immediate -> pc_out=0000, next imem_address=0000.
REQ-036 reset asserted in HOLD and in SQUASH -> next cycle imem_address=RESET_PC, buffered/pending data never delivered.
